conv_mac_engine: RTL and testbench

//  Parametrised multi-tap convolution datapath; successor to the single 8x8 multiply stage.

---
 rtl/conv_mac_engine_pkg.sv | 28 ++
 rtl/conv_mac_engine_if.sv | 34 +++
 rtl/conv_mac_engine_byte_reader.sv | 41 ++++
 rtl/conv_mac_engine.sv | 131 +++++++++++++
 tb/tb_conv_mac_engine.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_mac_engine_pkg.sv
// Shared types, defaults and width helpers for the convolution MAC engine.
package conv_mac_engine_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_TAPS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest accumulator that cannot overflow for the given operands/taps.
    function automatic int min_acc_w(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps);
    endfunction

    // Number of readout bytes covering an ACC_W-bit result.
    function automatic int nbytes(input int acc_w);
        return (acc_w + 7) / 8;
    endfunction

    // Counter width able to index n items, never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_mac_engine_if.sv
// Control, operand and readout bundle between a host and conv_mac_engine.
interface conv_mac_engine_if
    import conv_mac_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int ACC_W  = min_acc_w(DATA_W, TAPS),
    localparam int NBYTES = nbytes(ACC_W),
    localparam int PTR_W  = ptr_w(NBYTES)
);
    logic                     start;
    logic                     signed_mode;
    logic                     clear;
    logic [TAPS*DATA_W-1:0]   data_in;
    logic [TAPS*DATA_W-1:0]   weights_in;
    logic                     busy;
    logic                     done;
    logic [ACC_W-1:0]         result;
    logic                     rd_en;
    logic [7:0]               rd_byte;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     rd_wrap;

    modport master (
        output start, signed_mode, clear, data_in, weights_in, rd_en,
        input  busy, done, result, rd_byte, rd_ptr, rd_wrap
    );

    modport slave (
        input  start, signed_mode, clear, data_in, weights_in, rd_en,
        output busy, done, result, rd_byte, rd_ptr, rd_wrap
    );

endinterface

// File: rtl/conv_mac_engine_byte_reader.sv
// Byte-serial readout of the held result, LSB first, padded above ACC_W.
module conv_mac_engine_byte_reader
    import conv_mac_engine_pkg::*;
#(
    parameter int ACC_W = 18,
    localparam int NBYTES = nbytes(ACC_W),
    localparam int PTR_W  = ptr_w(NBYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] result,
    input  logic             mode,
    input  logic             rd_en,
    input  logic             reload,
    output logic [7:0]       rd_byte,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             wrap
);
    logic [NBYTES*8-1:0] ext;

    assign wrap = rd_en && (rd_ptr == PTR_W'(NBYTES - 1));

    // Byte pointer: reload (new result or clear) beats rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (reload) begin
            rd_ptr <= '0;
        end else if (rd_en) begin
            rd_ptr <= wrap ? '0 : rd_ptr + 1'b1;
        end
    end

    // Pad the result to whole bytes (sign or zero) and select the current byte.
    always_comb begin
        ext              = {(NBYTES*8){mode & result[ACC_W-1]}};
        ext[ACC_W-1:0]   = result;
        rd_byte          = ext[rd_ptr*8 +: 8];
    end

endmodule

// File: rtl/conv_mac_engine.sv
// Sequential multi-tap dot-product engine: one shared multiplier, one MAC per cycle.
module conv_mac_engine
    import conv_mac_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int ACC_W  = min_acc_w(DATA_W, TAPS)
) (
    input logic               clk,
    input logic               rst_n,
    conv_mac_engine_if.slave  bus
);
    localparam int IDX_W = ptr_w(TAPS);
    localparam int OW    = DATA_W + 1;
    localparam int PW    = 2 * OW;
    localparam int XW    = (ACC_W > PW) ? ACC_W : PW;

    state_t                 state_q, state_d;
    logic [TAPS*DATA_W-1:0] data_q, wts_q;
    logic                   mode_q;
    logic                   res_signed_q;
    logic [IDX_W-1:0]       idx_q;
    logic [ACC_W-1:0]       acc_q;
    logic [ACC_W-1:0]       result_q;
    logic                   done_q;

    logic [DATA_W-1:0]      d_sel, w_sel;
    logic signed [OW-1:0]   op_d, op_w;
    logic signed [PW-1:0]   prod;
    logic signed [XW-1:0]   prod_x;
    logic [ACC_W-1:0]       prod_ext;
    logic                   last_tap;

    assign last_tap    = (idx_q == IDX_W'(TAPS - 1));
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.result  = result_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; clear overrides everything, including a same-cycle start.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start) state_d = ST_MAC;
                ST_MAC:  if (last_tap)  state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Shared multiplier: operands widened by one bit so signed and unsigned
    // products both come out of a single signed multiply.
    always_comb begin
        d_sel    = data_q[idx_q*DATA_W +: DATA_W];
        w_sel    = wts_q[idx_q*DATA_W +: DATA_W];
        op_d     = mode_q ? {d_sel[DATA_W-1], d_sel} : {1'b0, d_sel};
        op_w     = mode_q ? {w_sel[DATA_W-1], w_sel} : {1'b0, w_sel};
        prod     = op_d * op_w;
        prod_x   = XW'(prod);
        prod_ext = prod_x[ACC_W-1:0];
    end

    // Operand snapshot, accumulation, result hold and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            wts_q        <= '0;
            mode_q       <= 1'b0;
            res_signed_q <= 1'b0;
            idx_q        <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
        end else if (bus.clear) begin
            idx_q        <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            res_signed_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        data_q <= bus.data_in;
                        wts_q  <= bus.weights_in;
                        mode_q <= bus.signed_mode;
                        acc_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_q + prod_ext;
                    idx_q <= idx_q + 1'b1;
                end
                ST_DONE: begin
                    result_q     <= acc_q;
                    res_signed_q <= mode_q;
                    done_q       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Padding follows the mode of the run that produced the held result,
    // so a new run's mode cannot alter readout of the old result mid-MAC.
    conv_mac_engine_byte_reader #(
        .ACC_W (ACC_W)
    ) u_reader (
        .clk     (clk),
        .rst_n   (rst_n),
        .result  (result_q),
        .mode    (res_signed_q),
        .rd_en   (bus.rd_en),
        .reload  (bus.clear || (state_q == ST_DONE)),
        .rd_byte (bus.rd_byte),
        .rd_ptr  (bus.rd_ptr),
        .wrap    (bus.rd_wrap)
    );

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine (DATA_W=8, TAPS=4, ACC_W=18).
module tb_conv_mac_engine;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    conv_mac_engine_if #(.DATA_W(8), .TAPS(4), .ACC_W(18)) bus ();

    conv_mac_engine #(.DATA_W(8), .TAPS(4), .ACC_W(18)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference dot product from the arithmetic definition.
    function automatic logic [17:0] ref_dot(input logic [31:0] d, input logic [31:0] w, input bit sgn);
        longint s;
        longint a;
        longint b;
        logic [63:0] sv;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            if (sgn) begin
                a = longint'($signed(d[i*8 +: 8]));
                b = longint'($signed(w[i*8 +: 8]));
            end else begin
                a = longint'({56'd0, d[i*8 +: 8]});
                b = longint'({56'd0, w[i*8 +: 8]});
            end
            s += a * b;
        end
        sv = s;
        return sv[17:0];
    endfunction

    // Reference readout byte k of an 18-bit result, sign- or zero-padded.
    function automatic logic [7:0] ref_byte(input logic [17:0] r, input bit sgn, input int k);
        longint v;
        logic [63:0] sh;
        v  = sgn ? longint'($signed(r)) : longint'({46'd0, r});
        sh = v >>> (8 * k);
        return sh[7:0];
    endfunction

    // One start pulse; lat = edges after the start edge until done is seen.
    task automatic do_run(input logic [31:0] d, input logic [31:0] w, input bit sgn, output int lat);
        @(negedge clk);
        bus.data_in     = d;
        bus.weights_in  = w;
        bus.signed_mode = sgn;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.clear       = 1'b0;
        bus.data_in     = '0;
        bus.weights_in  = '0;
        bus.rd_en       = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        total++; if (bus.result !== 18'd0) begin bad++; $display("FAIL reset_result got=%0h exp=0", bus.result); end
        total++; if (bus.rd_ptr !== 2'd0) begin bad++; $display("FAIL reset_rd_ptr got=%0d exp=0", bus.rd_ptr); end
        total++; if (bus.rd_byte !== 8'd0) begin bad++; $display("FAIL reset_rd_byte got=%0h exp=0", bus.rd_byte); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_basic;
        int lat;
        do_run(32'h04030201, 32'h08070605, 1'b0, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        total++; if (bus.result !== 18'd70) begin bad++; $display("FAIL basic_result got=%0d exp=70", bus.result); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%0b exp=0", bus.busy); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0b exp=0", bus.done); end
        total++; if (bus.result !== 18'd70) begin bad++; $display("FAIL basic_result_hold got=%0d exp=70", bus.result); end
    endtask

    task automatic test_unsigned_max;
        int lat;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h04; exp_b[1] = 8'hF8; exp_b[2] = 8'h03; exp_b[3] = 8'h04;
        do_run('1, '1, 1'b0, lat);
        total++; if (bus.result !== 18'h3F804) begin bad++; $display("FAIL max_result got=%0h exp=3f804", bus.result); end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.rd_byte !== exp_b[i]) begin bad++; $display("FAIL max_byte%0d got=%0h exp=%0h", i, bus.rd_byte, exp_b[i]); end
            @(negedge clk);
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_signed;
        int lat;
        do_run(32'h80808080, 32'h80808080, 1'b1, lat);
        total++; if (bus.result !== 18'h10000) begin bad++; $display("FAIL sgn_negneg got=%0h exp=10000", bus.result); end
        do_run(32'h80808080, 32'h7F7F7F7F, 1'b1, lat);
        total++; if (bus.result !== 18'h30200) begin bad++; $display("FAIL sgn_negpos got=%0h exp=30200", bus.result); end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.rd_byte !== ref_byte(18'h30200, 1'b1, i)) begin
                bad++; $display("FAIL sgn_byte%0d got=%0h exp=%0h", i, bus.rd_byte, ref_byte(18'h30200, 1'b1, i));
            end
            @(negedge clk);
        end
        bus.rd_en = 1'b0;
        total++; if (ref_byte(18'h30200, 1'b1, 2) !== 8'hFF || bus.rd_ptr !== 2'd0) begin
            bad++; $display("FAIL sgn_wrap_ptr got=%0d exp=0", bus.rd_ptr);
        end
    endtask

    task automatic test_random;
        int lat;
        logic [31:0] d, w;
        bit sgn;
        logic [17:0] er;
        for (int n = 0; n < 24; n++) begin
            d   = $urandom;
            w   = $urandom;
            sgn = 1'($urandom_range(0, 1));
            er  = ref_dot(d, w, sgn);
            do_run(d, w, sgn, lat);
            total++; if (lat !== 5) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=5", n, lat); end
            total++; if (bus.result !== er) begin bad++; $display("FAIL rnd%0d_result got=%0h exp=%0h", n, bus.result, er); end
            bus.rd_en = 1'b1;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (bus.rd_byte !== ref_byte(er, sgn, i)) begin
                    bad++; $display("FAIL rnd%0d_byte%0d got=%0h exp=%0h", n, i, bus.rd_byte, ref_byte(er, sgn, i));
                end
                @(negedge clk);
            end
            bus.rd_en = 1'b0;
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        logic [17:0] er;
        er = ref_dot(32'h11223344, 32'h05060708, 1'b0);
        @(negedge clk);
        bus.data_in = 32'h11223344; bus.weights_in = 32'h05060708; bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_in_mac got=%0b exp=1", bus.busy); end
        bus.start = 1'b1; bus.data_in = '1; bus.weights_in = '1; bus.signed_mode = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 2;
        while (bus.done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        total++; if (lat !== 5) begin bad++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
        total++; if (bus.result !== er) begin bad++; $display("FAIL ignore_result got=%0h exp=%0h", bus.result, er); end
        lat = 0;
        repeat (8) begin @(negedge clk); if (bus.busy === 1'b1) lat++; end
        total++; if (lat !== 0) begin bad++; $display("FAIL ignore_no_queue busy_cycles=%0d exp=0", lat); end
    endtask

    task automatic test_back_to_back;
        int gap;
        logic [17:0] er2;
        er2 = ref_dot(32'h0A0B0C0D, 32'h01020304, 1'b0);
        @(negedge clk);
        bus.data_in = 32'h01010101; bus.weights_in = 32'h02020202; bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        gap = 0;
        while (bus.done !== 1'b1 && gap < 20) begin @(negedge clk); gap++; end
        bus.data_in = 32'h0A0B0C0D; bus.weights_in = 32'h01020304;
        total++; if (bus.result !== 18'd8) begin bad++; $display("FAIL b2b_first got=%0d exp=8", bus.result); end
        @(negedge clk);
        gap = 1;
        while (bus.done !== 1'b1 && gap < 20) begin @(negedge clk); gap++; end
        bus.start = 1'b0;
        total++; if (gap !== 6) begin bad++; $display("FAIL b2b_period got=%0d exp=6", gap); end
        total++; if (bus.result !== er2) begin bad++; $display("FAIL b2b_second got=%0h exp=%0h", bus.result, er2); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int lat;
        int seen;
        logic [17:0] er;
        @(negedge clk);
        bus.data_in = 32'h7F7F7F7F; bus.weights_in = 32'h7F7F7F7F; bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.result !== 18'd0) begin bad++; $display("FAIL rst_mid_result got=%0h exp=0", bus.result); end
        seen = 0;
        repeat (2) begin @(negedge clk); if (bus.done === 1'b1) seen++; end
        rst_n = 1'b1;
        repeat (8) begin @(negedge clk); if (bus.done === 1'b1 || bus.busy === 1'b1) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen); end
        er = ref_dot(32'hFF01FE02, 32'h03FD04FC, 1'b1);
        do_run(32'hFF01FE02, 32'h03FD04FC, 1'b1, lat);
        total++; if (lat !== 5 || bus.result !== er) begin
            bad++; $display("FAIL rst_mid_rerun got=%0h lat=%0d exp=%0h lat=5", bus.result, lat, er);
        end
    endtask

    task automatic test_clear;
        int lat;
        int seen;
        logic [17:0] er;
        do_run(32'h04030201, 32'h08070605, 1'b0, lat);
        @(negedge clk);
        bus.clear = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0; bus.start = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL clr_start_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.result !== 18'd0) begin bad++; $display("FAIL clr_result got=%0h exp=0", bus.result); end
        bus.rd_en = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.rd_ptr !== 2'd2) begin bad++; $display("FAIL clr_rd_ptr_adv got=%0d exp=2", bus.rd_ptr); end
        er = ref_dot(32'h00FF00FF, 32'hFF00FF00, 1'b0);
        do_run(32'h00FF00FF, 32'hFF00FF00, 1'b0, lat);
        bus.rd_en = 1'b0;
        total++; if (bus.rd_ptr !== 2'd0) begin bad++; $display("FAIL done_rd_ptr got=%0d exp=0", bus.rd_ptr); end
        total++; if (lat !== 5 || bus.result !== er) begin bad++; $display("FAIL clr_rerun got=%0h exp=%0h", bus.result, er); end
        do_run(32'h05050505, 32'h05050505, 1'b0, lat);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.result !== 18'd0) begin
            bad++; $display("FAIL clr_mid got busy=%0b result=%0h exp busy=0 result=0", bus.busy, bus.result);
        end
        seen = 0;
        repeat (8) begin @(negedge clk); if (bus.done === 1'b1) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL clr_mid_no_done got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_unsigned_max();
        test_signed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
